// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the line fetch engine.
// Holds the fetch command encoding, the line fetch FSM state type and the
// cache data-memory read priority used by the victim read.
// Build option: LINE_FETCH_WB_EN adds the writeback (WB_*) states.
package cache_pkg;
  typedef enum logic [1:0] {
    FETCH_ONLY = 2'b01,
    WB_FETCH   = 2'b10
  } fetch_cmd_t;
  typedef enum logic [2:0] {
    IDLE,
`ifdef LINE_FETCH_WB_EN
    WB_RD,
    WB_WAIT,
    WB_SEND,
`endif
    FILL_REQ,
    FILL_DATA,
    DONE
  } line_fetch_state_t;
  localparam logic [1:0] MEM_PRI_FETCH = 2'b10;
endpackage

// File: rtl/line_fetch_engine_if.sv
// line_fetch_engine_if: bus bundle of the line fetch engine.
// Groups the fetch command handshake, the cache data-memory read and write
// ports and the external read/write burst signals.
// Modports: slave = the engine, master = the surrounding controller/memories.
interface line_fetch_engine_if #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
);
  localparam int TW = $clog2(list_depth);
  localparam int CW = $clog2(list_width);
  logic                  fetch_req;
  logic [1:0]            fetch_cmd;
  logic [TW-1:0]         fetch_tag;
  logic [addr_width-1:0] fetch_addr;
  logic [addr_width-1:0] fetch_addr_pre;
  logic                  fetch_gnt;
  logic                  fetch_done;
  logic [TW+CW-1:0]      mem_raddr;
  logic                  mem_ren;
  logic [1:0]            mem_rpri;
  logic                  mem_rready;
  logic [data_width-1:0] mem_rdata;
  logic                  mem_rdata_valid;
  logic [TW+CW-1:0]      mem_waddr;
  logic                  mem_wen;
  logic [data_width-1:0] mem_wdata;
  logic                  mem_wready;
  logic                  ext_rd_req;
  logic [addr_width-1:0] ext_rd_addr;
  logic                  ext_rd_gnt;
  logic [data_width-1:0] ext_rd_data;
  logic                  ext_rd_data_valid;
  logic                  ext_rd_ready;
  logic                  ext_wr_valid;
  logic                  ext_wr_ready;
  logic [addr_width-1:0] ext_wr_addr;
  logic [data_width-1:0] ext_wr_data;
  logic                  ext_wr_last;
  modport slave (
    input  fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
    input  mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
    input  ext_rd_gnt, ext_rd_data, ext_rd_data_valid, ext_wr_ready,
    output fetch_gnt, fetch_done, mem_raddr, mem_ren, mem_rpri,
    output mem_waddr, mem_wen, mem_wdata,
    output ext_rd_req, ext_rd_addr, ext_rd_ready,
    output ext_wr_valid, ext_wr_addr, ext_wr_data, ext_wr_last
  );
  modport master (
    output fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
    output mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
    output ext_rd_gnt, ext_rd_data, ext_rd_data_valid, ext_wr_ready,
    input  fetch_gnt, fetch_done, mem_raddr, mem_ren, mem_rpri,
    input  mem_waddr, mem_wen, mem_wdata,
    input  ext_rd_req, ext_rd_addr, ext_rd_ready,
    input  ext_wr_valid, ext_wr_addr, ext_wr_data, ext_wr_last
  );
endinterface

// File: rtl/line_fetch_engine.sv
// line_fetch_engine: line fill / dirty-victim writeback engine.
// Ports: clk; rst_n (synchronous, active-low); bus (line_fetch_engine_if.slave)
//   carrying the fetch command handshake, cache data-memory read/write ports
//   and external read/write bursts.
// Build option: LINE_FETCH_WB_EN includes the victim writeback path; when it is
//   undefined every command is fill-only and the read-port and external write
//   outputs are tied to 0.
module line_fetch_engine
  import cache_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input logic                clk,
  input logic                rst_n,
  line_fetch_engine_if.slave bus
);
  localparam int TW = $clog2(list_depth);
  localparam int CW = $clog2(list_width);
  line_fetch_state_t     r_state;
  logic [TW-1:0]         r_tag;
  logic [addr_width-1:0] r_addr;
  logic [CW-1:0]         r_cnt;
  logic                  w_last;
  logic                  w_fill;
`ifdef LINE_FETCH_WB_EN
  logic [addr_width-1:0] r_addr_pre;
  logic [data_width-1:0] r_wb_data;
  logic                  w_rd;
  logic                  w_send;
`endif
  assign w_last = r_cnt == CW'(list_width - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_tag   <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
`ifdef LINE_FETCH_WB_EN
      r_addr_pre <= '0;
      r_wb_data  <= '0;
`endif
    end else
      case (r_state)
        IDLE:
          if (bus.fetch_req) begin
            r_tag  <= bus.fetch_tag;
            r_addr <= bus.fetch_addr;
            r_cnt  <= '0;
`ifdef LINE_FETCH_WB_EN
            r_addr_pre <= bus.fetch_addr_pre;
            r_state    <= bus.fetch_cmd == WB_FETCH ? WB_RD : FILL_REQ;
`else
            r_state <= FILL_REQ;
`endif
          end
`ifdef LINE_FETCH_WB_EN
        WB_RD: if (bus.mem_rready) r_state <= WB_WAIT;
        WB_WAIT:
          if (bus.mem_rdata_valid) begin
            r_wb_data <= bus.mem_rdata;
            r_state   <= WB_SEND;
          end
        WB_SEND:
          if (bus.ext_wr_ready) begin
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_state <= w_last ? FILL_REQ : WB_RD;
          end
`endif
        FILL_REQ:
          if (bus.ext_rd_gnt) begin
            r_cnt   <= '0;
            r_state <= FILL_DATA;
          end
        FILL_DATA:
          if (bus.ext_rd_data_valid && bus.mem_wready) begin
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_state <= w_last ? DONE : FILL_DATA;
          end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
  // Every output is qualified by rst_n so the block is silent while held in reset.
  assign w_fill           = rst_n && r_state == FILL_DATA;
  assign bus.fetch_gnt    = rst_n && r_state == IDLE;
  assign bus.fetch_done   = rst_n && r_state == DONE;
  assign bus.ext_rd_req   = rst_n && r_state == FILL_REQ;
  assign bus.ext_rd_addr  = rst_n && r_state == FILL_REQ ? r_addr : '0;
  // A beat is only taken when the cache can absorb it in the same cycle.
  assign bus.ext_rd_ready = w_fill && bus.mem_wready;
  assign bus.mem_wen      = w_fill && bus.ext_rd_data_valid;
  assign bus.mem_wdata    = w_fill ? bus.ext_rd_data : '0;
  assign bus.mem_waddr    = w_fill ? {r_tag, r_cnt} : '0;
`ifdef LINE_FETCH_WB_EN
  assign w_rd             = rst_n && r_state == WB_RD;
  assign w_send           = rst_n && r_state == WB_SEND;
  assign bus.mem_ren      = w_rd;
  assign bus.mem_raddr    = w_rd ? {r_tag, r_cnt} : '0;
  assign bus.mem_rpri     = w_rd ? MEM_PRI_FETCH : 2'b00;
  assign bus.ext_wr_valid = w_send;
  assign bus.ext_wr_addr  = w_send ? r_addr_pre : '0;
  assign bus.ext_wr_data  = w_send ? r_wb_data : '0;
  assign bus.ext_wr_last  = w_send && w_last;
`else
  assign bus.mem_ren      = 1'b0;
  assign bus.mem_raddr    = '0;
  assign bus.mem_rpri     = 2'b00;
  assign bus.ext_wr_valid = 1'b0;
  assign bus.ext_wr_addr  = '0;
  assign bus.ext_wr_data  = '0;
  assign bus.ext_wr_last  = 1'b0;
`endif
endmodule

// File: tb/tb_line_fetch_engine.sv
// tb_line_fetch_engine: self-checking bench for line_fetch_engine with a
// scoreboard of expected cache writes and external write beats.
module tb_line_fetch_engine;
  import cache_pkg::*;
  localparam int AW = 32, LD = 4, DW = 32, LW = 32, TW = 2, CW = 5;
  typedef struct packed {logic [TW+CW-1:0] a; logic [DW-1:0] d;} mw_t;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic l;} ew_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  line_fetch_engine_if #(.addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)) bus ();
  line_fetch_engine #(.addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  mw_t exp_mw[$];
  ew_t exp_ew[$];
  mw_t e_mw;
  ew_t e_ew;
  int checks = 0, errors = 0;
  int cyc = 0, hs_cnt = 0, hs_cyc = 0, done_cnt = 0, done_cyc = 0;
  int rdreq_cyc = 0, ew_cnt = 0, last_cnt = 0, mw_cnt = 0, ren_cnt = 0, beat_idx = 0;
  logic [AW-1:0] rdreq_addr = '0;
  bit fill_active = 0, rd_pend = 0, bp = 0;
  logic [TW+CW-1:0] rd_addr = '0;
  logic [DW-1:0] cmem [LD*LW];
  logic [DW-1:0] fill_base = 32'hA000;
  logic any_out;
  assign any_out = |{bus.fetch_gnt, bus.fetch_done, bus.mem_raddr, bus.mem_ren, bus.mem_rpri,
                     bus.mem_waddr, bus.mem_wen, bus.mem_wdata, bus.ext_rd_req, bus.ext_rd_addr,
                     bus.ext_rd_ready, bus.ext_wr_valid, bus.ext_wr_addr, bus.ext_wr_data,
                     bus.ext_wr_last};
  // Responders: inputs change only 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    bus.mem_rready = 1'b1;
    bus.mem_wready = bp ? 1'($urandom_range(1)) : 1'b1;
    bus.ext_wr_ready = bp ? ($urandom_range(2) == 0) : 1'b1;
    bus.mem_rdata_valid = rd_pend;
    bus.mem_rdata = rd_pend ? cmem[rd_addr] : '0;
    rd_pend = 0;
    bus.ext_rd_data_valid = fill_active;
    bus.ext_rd_data = fill_base + DW'(beat_idx);
  end
  // Monitor: transfers seen here commit at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      fill_active = 0;
      rd_pend = 0;
      beat_idx = 0;
    end else begin
      if (bus.fetch_req && bus.fetch_gnt) begin hs_cnt++; hs_cyc = cyc; end
      if (bus.fetch_done) begin done_cnt++; done_cyc = cyc; end
      if (bus.ext_rd_req && bus.ext_rd_gnt) begin
        rdreq_cyc = cyc; rdreq_addr = bus.ext_rd_addr; fill_active = 1; beat_idx = 0;
      end
      if (bus.mem_ren && bus.mem_rready) begin ren_cnt++; rd_pend = 1; rd_addr = bus.mem_raddr; end
      if (bus.ext_rd_data_valid && bus.ext_rd_ready) begin
        beat_idx++;
        if (beat_idx == LW) fill_active = 0;
      end
      if (bus.mem_wen && bus.mem_wready) begin
        mw_cnt++; checks++;
        if (exp_mw.size() == 0) begin
          errors++; $display("FAIL mem_write unexpected: addr=%h data=%h required none", bus.mem_waddr, bus.mem_wdata);
        end else begin
          e_mw = exp_mw.pop_front();
          if (bus.mem_waddr !== e_mw.a || bus.mem_wdata !== e_mw.d) begin
            errors++; $display("FAIL mem_write: addr=%h data=%h required addr=%h data=%h",
                               bus.mem_waddr, bus.mem_wdata, e_mw.a, e_mw.d);
          end
        end
      end
      if (bus.ext_wr_valid && bus.ext_wr_ready) begin
        ew_cnt++; checks++;
        if (bus.ext_wr_last) last_cnt++;
        if (exp_ew.size() == 0) begin
          errors++; $display("FAIL ext_write unexpected: addr=%h data=%h required none", bus.ext_wr_addr, bus.ext_wr_data);
        end else begin
          e_ew = exp_ew.pop_front();
          if (bus.ext_wr_addr !== e_ew.a || bus.ext_wr_data !== e_ew.d || bus.ext_wr_last !== e_ew.l) begin
            errors++; $display("FAIL ext_write: addr=%h data=%h last=%b required addr=%h data=%h last=%b",
                               bus.ext_wr_addr, bus.ext_wr_data, bus.ext_wr_last, e_ew.a, e_ew.d, e_ew.l);
          end
        end
      end
    end
  end
  task automatic push_fill(input int tag);
    for (int i = 0; i < LW; i++) exp_mw.push_back(mw_t'({TW'(tag), CW'(i), fill_base + DW'(i)}));
  endtask
  task automatic push_wb(input int tag, input logic [AW-1:0] pre);
    for (int i = 0; i < LW; i++) exp_ew.push_back(ew_t'({pre, cmem[tag*LW+i], i == LW - 1}));
  endtask
  task automatic send(input logic [1:0] c, input int tag, input logic [AW-1:0] a, input logic [AW-1:0] pre);
    int h0 = hs_cnt;
    @(posedge clk); #1;
    bus.fetch_req = 1'b1; bus.fetch_cmd = c; bus.fetch_tag = TW'(tag);
    bus.fetch_addr = a; bus.fetch_addr_pre = pre;
    for (int k = 0; k < 400 && hs_cnt == h0; k++) begin @(negedge clk); #1; end
    checks++;
    if (hs_cnt == h0) begin errors++; $display("FAIL handshake: gnt never seen, required within 400 cycles"); end
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
  endtask
  task automatic wait_done(input int n0, input int budget);
    for (int k = 0; k < budget && done_cnt == n0; k++) begin @(negedge clk); #1; end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (any_out !== 1'b0) begin errors++; $display("FAIL reset_outs: or_of_outputs=%b required 0", any_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fetch_gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt: gnt=%b required 1", bus.fetch_gnt); end
    checks++;
    if ({bus.fetch_done, bus.ext_rd_req, bus.mem_wen, bus.ext_wr_valid, bus.mem_ren} !== 5'b0) begin
      errors++; $display("FAIL reset_idle: done/rdreq/wen/wrvalid/ren=%b required 00000",
                         {bus.fetch_done, bus.ext_rd_req, bus.mem_wen, bus.ext_wr_valid, bus.mem_ren});
    end
  endtask
  task automatic test_fill_only;
    int n0 = done_cnt, ew0 = ew_cnt, t0;
    fill_base = 32'hA000;
    push_fill(2);
    send(2'b01, 2, 32'h0000_1000, 32'h0);
    t0 = hs_cyc;
    wait_done(n0, 200);
    checks++;
    if (done_cnt !== n0 + 1) begin errors++; $display("FAIL fill_done_count: %0d required %0d", done_cnt - n0, 1); end
    checks++;
    if (done_cyc !== t0 + 34) begin errors++; $display("FAIL fill_done_time: T0+%0d required T0+34", done_cyc - t0); end
    checks++;
    if (rdreq_cyc !== t0 + 1) begin errors++; $display("FAIL fill_rdreq_time: T0+%0d required T0+1", rdreq_cyc - t0); end
    checks++;
    if (rdreq_addr !== 32'h0000_1000) begin errors++; $display("FAIL fill_rdreq_addr: %h required 00001000", rdreq_addr); end
    checks++;
    if (exp_mw.size() != 0) begin errors++; $display("FAIL fill_missing_writes: %0d left required 0", exp_mw.size()); end
    checks++;
    if (ew_cnt != ew0) begin errors++; $display("FAIL fill_ext_writes: %0d required 0", ew_cnt - ew0); end
    @(negedge clk);
    checks++;
    if (bus.fetch_done !== 1'b0 || bus.fetch_gnt !== 1'b1) begin
      errors++; $display("FAIL fill_after_done: done=%b gnt=%b required done=0 gnt=1", bus.fetch_done, bus.fetch_gnt);
    end
  endtask
`ifdef LINE_FETCH_WB_EN
  task automatic test_writeback;
    int n0 = done_cnt, ew0 = ew_cnt, l0 = last_cnt, r0 = ren_cnt, t0;
    fill_base = 32'hC000;
    push_wb(1, 32'h0000_2000);
    push_fill(1);
    send(2'b10, 1, 32'h0000_3000, 32'h0000_2000);
    t0 = hs_cyc;
    wait_done(n0, 400);
    checks++;
    if (done_cyc !== t0 + 34 + 3 * LW) begin errors++; $display("FAIL wb_done_time: T0+%0d required T0+%0d", done_cyc - t0, 34 + 3 * LW); end
    checks++;
    if (ew_cnt - ew0 != LW) begin errors++; $display("FAIL wb_beats: %0d required %0d", ew_cnt - ew0, LW); end
    checks++;
    if (last_cnt - l0 != 1) begin errors++; $display("FAIL wb_last_count: %0d required 1", last_cnt - l0); end
    checks++;
    if (ren_cnt - r0 != LW) begin errors++; $display("FAIL wb_reads: %0d required %0d", ren_cnt - r0, LW); end
    checks++;
    if (exp_ew.size() != 0 || exp_mw.size() != 0) begin
      errors++; $display("FAIL wb_left: ext=%0d mem=%0d required 0 0", exp_ew.size(), exp_mw.size());
    end
    checks++;
    if (rdreq_addr !== 32'h0000_3000) begin errors++; $display("FAIL wb_rdreq_addr: %h required 00003000", rdreq_addr); end
  endtask
`else
  task automatic test_no_wb;
    int n0 = done_cnt, ew0 = ew_cnt, r0 = ren_cnt, t0;
    fill_base = 32'hC000;
    push_fill(1);
    send(2'b10, 1, 32'h0000_3000, 32'h0000_2000);
    t0 = hs_cyc;
    wait_done(n0, 200);
    checks++;
    if (rdreq_cyc !== t0 + 1) begin errors++; $display("FAIL nowb_rdreq_time: T0+%0d required T0+1", rdreq_cyc - t0); end
    checks++;
    if (done_cyc !== t0 + 34) begin errors++; $display("FAIL nowb_done_time: T0+%0d required T0+34", done_cyc - t0); end
    checks++;
    if (ew_cnt != ew0 || ren_cnt != r0) begin
      errors++; $display("FAIL nowb_wb_activity: ext_writes=%0d reads=%0d required 0 0", ew_cnt - ew0, ren_cnt - r0);
    end
    checks++;
    if (exp_mw.size() != 0) begin errors++; $display("FAIL nowb_missing_writes: %0d left required 0", exp_mw.size()); end
  endtask
`endif
  task automatic test_backpressure;
    int n0 = done_cnt, m0 = mw_cnt, ew0 = ew_cnt;
    bp = 1;
    fill_base = 32'hD000;
`ifdef LINE_FETCH_WB_EN
    push_wb(0, 32'h0000_4000);
    push_fill(0);
    send(2'b10, 0, 32'h0000_5000, 32'h0000_4000);
`else
    push_fill(3);
    send(2'b01, 3, 32'h0000_5000, 32'h0000_4000);
`endif
    wait_done(n0, 2000);
    bp = 0;
    checks++;
    if (done_cnt !== n0 + 1) begin errors++; $display("FAIL bp_done_count: %0d required 1", done_cnt - n0); end
    checks++;
    if (mw_cnt - m0 != LW) begin errors++; $display("FAIL bp_mem_writes: %0d required %0d", mw_cnt - m0, LW); end
    checks++;
`ifdef LINE_FETCH_WB_EN
    if (ew_cnt - ew0 != LW) begin errors++; $display("FAIL bp_ext_writes: %0d required %0d", ew_cnt - ew0, LW); end
`else
    if (ew_cnt != ew0) begin errors++; $display("FAIL bp_ext_writes: %0d required 0", ew_cnt - ew0); end
`endif
    checks++;
    if (exp_mw.size() != 0 || exp_ew.size() != 0) begin
      errors++; $display("FAIL bp_left: mem=%0d ext=%0d required 0 0", exp_mw.size(), exp_ew.size());
    end
  endtask
  task automatic test_ignored;
    int n0 = done_cnt, h0, busy_gnt = 0;
    fill_base = 32'hE000;
    push_fill(0);
    send(2'b01, 0, 32'h0000_6000, 32'h0);
    for (int k = 0; k < 200 && !(fill_active && beat_idx >= 5); k++) begin @(negedge clk); #1; end
    h0 = hs_cnt;
    push_fill(3);
    @(posedge clk); #1;
    bus.fetch_req = 1'b1; bus.fetch_cmd = 2'b01; bus.fetch_tag = 2'd3; bus.fetch_addr = 32'h0000_7000;
    @(negedge clk);
    checks++;
    if (bus.fetch_gnt !== 1'b0) begin errors++; $display("FAIL ignored_gnt: gnt=%b required 0 in FILL_DATA", bus.fetch_gnt); end
    for (int k = 0; k < 200 && hs_cnt == h0; k++) begin
      if (bus.fetch_gnt && done_cnt == n0) busy_gnt++;
      @(negedge clk); #1;
    end
    checks++;
    if (busy_gnt != 0) begin errors++; $display("FAIL ignored_busy_gnt: %0d cycles required 0", busy_gnt); end
    checks++;
    if (hs_cnt == h0 || hs_cyc !== done_cyc + 1) begin
      errors++; $display("FAIL ignored_accept: accepted=%0d at DONE+%0d required 1 at DONE+1", hs_cnt - h0, hs_cyc - done_cyc);
    end
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
    wait_done(n0 + 1, 200);
    checks++;
    if (done_cnt !== n0 + 2 || exp_mw.size() != 0) begin
      errors++; $display("FAIL ignored_second: done=%0d left=%0d required 2 0", done_cnt - n0, exp_mw.size());
    end
  endtask
  task automatic test_reset_mid_fill;
    int n0 = done_cnt, m0;
    fill_base = 32'hF000;
    push_fill(2);
    send(2'b01, 2, 32'h0000_8000, 32'h0);
    for (int k = 0; k < 200 && !(fill_active && beat_idx >= 10); k++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (any_out !== 1'b0) begin errors++; $display("FAIL midrst_outs: or_of_outputs=%b required 0", any_out); end
    checks++;
    if (exp_mw.size() == 0) begin errors++; $display("FAIL midrst_abandon: 0 words left required >0"); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_mw.delete();
    m0 = mw_cnt;
    @(negedge clk);
    checks++;
    if (bus.fetch_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt: gnt=%b required 1", bus.fetch_gnt); end
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt != n0 || mw_cnt != m0) begin
      errors++; $display("FAIL midrst_quiet: done=%0d writes=%0d required 0 0", done_cnt - n0, mw_cnt - m0);
    end
  endtask
  initial begin
    bus.fetch_req = 1'b0; bus.fetch_cmd = 2'b00; bus.fetch_tag = '0;
    bus.fetch_addr = '0; bus.fetch_addr_pre = '0;
    bus.mem_rready = 1'b1; bus.mem_rdata = '0; bus.mem_rdata_valid = 1'b0; bus.mem_wready = 1'b1;
    bus.ext_rd_gnt = 1'b1; bus.ext_rd_data = '0; bus.ext_rd_data_valid = 1'b0; bus.ext_wr_ready = 1'b1;
    for (int s = 0; s < LD; s++)
      for (int i = 0; i < LW; i++)
        cmem[s*LW+i] = (s == 1) ? 32'hB000 + DW'(i) : 32'h9000 + DW'(s * 256 + i);
    test_reset;
    test_fill_only;
`ifdef LINE_FETCH_WB_EN
    test_writeback;
`else
    test_no_wb;
`endif
    test_backpressure;
    test_ignored;
    test_reset_mid_fill;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
